// File: rtl/alu_issue_seq.sv
// alu_issue_seq: single-command sequencer in front of an external ALU.
// Latches a command, drives the ALU for SETTLE cycles, then presents the result.
module alu_issue_seq #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_cmd,
  output logic             out_zero,
  output logic [15:0]      op_count,
  output logic             err_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_d;
  logic [3:0] cnt;
  logic [4:0] op_d;
  logic       accept;
  logic       illegal;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign accept    = in_ready && in_valid;
  assign illegal   = (in_cmd == 3'd7);

  // Opcode to ALU operation code.
  always_comb begin
    op_d = 5'b00000;
    case (in_cmd)
      3'd0:    op_d = 5'b00000;
      3'd1:    op_d = 5'b00001;
      3'd2:    op_d = 5'b00010;
      3'd3:    op_d = 5'b01110;
      3'd4:    op_d = 5'b01111;
      3'd5:    op_d = 5'b11000;
      3'd6:    op_d = 5'b11001;
      default: op_d = 5'b00000;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == IDLE): if (in_valid) state_d = illegal ? RESP : EXEC;
      (state == EXEC): if (cnt == 4'd1) state_d = RESP;
      (state == RESP): if (out_ready) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Datapath: command latch, settle counter, result capture, stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 4'd0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 5'b00000;
      out_result  <= '0;
      out_cmd     <= 3'd0;
      out_zero    <= 1'b1;
      op_count    <= 16'd0;
      err_illegal <= 1'b0;
    end else if (accept) begin
      out_cmd <= in_cmd;
      if (illegal) begin
        out_result  <= '0;
        out_zero    <= 1'b1;
        err_illegal <= 1'b1;
      end else begin
        alu_a  <= in_a;
        alu_b  <= in_b;
        alu_op <= op_d;
        cnt    <= 4'(SETTLE);
      end
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        out_result <= alu_s;
        out_zero   <= (alu_s == '0);
      end
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed bench for alu_issue_seq.
// Models the downstream ALU and checks handshakes, results and reset abort.
module tb_alu_issue_seq;
  localparam int W = 32;

  logic         clk = 0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic         out_zero, err_illegal;
  logic [2:0]   in_cmd, out_cmd;
  logic [W-1:0] in_a, in_b, alu_a, alu_b, alu_s, out_result;
  logic [4:0]   alu_op;
  logic [15:0]  op_count;

  logic         rst3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic         out_zero3, err3;
  logic [2:0]   in_cmd3, out_cmd3;
  logic [W-1:0] in_a3, in_b3, alu_a3, alu_b3, alu_s3, out_result3;
  logic [4:0]   alu_op3;
  logic [15:0]  op_count3;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(
    input logic [W-1:0] a, input logic [4:0] op, input logic [W-1:0] b);
    case (op)
      5'b00000: alu_f = a & b;
      5'b00001: alu_f = a | b;
      5'b00010: alu_f = a + b;
      5'b01110: alu_f = a - b;
      5'b01111: alu_f = ($signed(a) < $signed(b)) ? 1 : 0;
      5'b11000: alu_f = ~(a | b);
      5'b11001: alu_f = ~(a & b);
      default:  alu_f = 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_s  = alu_f(alu_a, alu_op, alu_b);
  assign alu_s3 = alu_f(alu_a3, alu_op3, alu_b3);

  alu_issue_seq #(.WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_a(in_a), .in_b(in_b), .alu_a(alu_a),
    .alu_op(alu_op), .alu_b(alu_b), .alu_s(alu_s), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_cmd(out_cmd),
    .out_zero(out_zero), .op_count(op_count), .err_illegal(err_illegal));

  alu_issue_seq #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_cmd(in_cmd3), .in_a(in_a3), .in_b(in_b3), .alu_a(alu_a3),
    .alu_op(alu_op3), .alu_b(alu_b3), .alu_s(alu_s3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_result(out_result3), .out_cmd(out_cmd3),
    .out_zero(out_zero3), .op_count(op_count3), .err_illegal(err3));

  // Issue one command on dut at a negedge, wait for the result, handshake.
  task automatic do_op(input logic [2:0] cmd, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er,
                       input logic [4:0] eop, input int elat);
    int lat;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL op_in_ready: got %b want 1", in_ready);
    end
    in_valid = 1; in_cmd = cmd; in_a = a; in_b = b;
    @(posedge clk); #1 in_valid = 0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
    n_cmp++;
    if (lat != elat) begin
      n_bad++; $display("FAIL op_latency cmd%0d: got %0d want %0d", cmd, lat, elat);
    end
    n_cmp++;
    if (out_result !== er) begin
      n_bad++; $display("FAIL op_result cmd%0d: got %h want %h", cmd, out_result, er);
    end
    n_cmp++;
    if (out_zero !== (er == 0)) begin
      n_bad++; $display("FAIL op_zero cmd%0d: got %b want %b", cmd, out_zero, er == 0);
    end
    n_cmp++;
    if (out_cmd !== cmd) begin
      n_bad++; $display("FAIL op_cmd: got %0d want %0d", out_cmd, cmd);
    end
    n_cmp++;
    if (alu_op !== eop) begin
      n_bad++; $display("FAIL op_aluop cmd%0d: got %b want %b", cmd, alu_op, eop);
    end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    exp_cnt++;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL op_done: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    n_cmp++;
    if (op_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL op_count: got %0d want %0d", op_count, exp_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0; rst3 = 0;
    in_valid = 0; in_cmd = 0; in_a = 0; in_b = 0; out_ready = 0;
    in_valid3 = 0; in_cmd3 = 0; in_a3 = 0; in_b3 = 0; out_ready3 = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_zero, err_illegal} !== 4'b1010) begin
      n_bad++; $display("FAIL reset_flags: got %b want 1010",
                        {in_ready, out_valid, out_zero, err_illegal});
    end
    n_cmp++;
    if ({alu_a, alu_b, out_result} !== '0 || alu_op !== 0 ||
        out_cmd !== 0 || op_count !== 0) begin
      n_bad++; $display("FAIL reset_regs: got a=%h b=%h r=%h op=%b c=%0d n=%0d want 0",
                        alu_a, alu_b, out_result, alu_op, out_cmd, op_count);
    end
    rst_n = 1; rst3 = 1;
    do_op(3'd0, 45, 21, 5, 5'b00000, 2);
  endtask

  task automatic test_arith;
    do_op(3'd2, 45, 21, 66, 5'b00010, 2);
    do_op(3'd3, 45, 21, 24, 5'b01110, 2);
    do_op(3'd3, 21, 45, 32'hFFFFFFE8, 5'b01110, 2);
  endtask

  task automatic test_logic;
    do_op(3'd4, 21, 45, 1, 5'b01111, 2);
    do_op(3'd4, 45, 21, 0, 5'b01111, 2);
    do_op(3'd5, 21, 45, 32'hFFFFFFC2, 5'b11000, 2);
    do_op(3'd6, 21, 45, 32'hFFFFFFFA, 5'b11001, 2);
  endtask

  task automatic test_stall;
    int t;
    in_valid = 1; in_cmd = 3'd1; in_a = 45; in_b = 21;
    @(posedge clk); #1 in_valid = 0;
    t = 0;
    while (out_valid !== 1'b1 && t < 40) begin
      @(posedge clk); #1 t++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin in_valid = 1; in_cmd = 3'd2; in_a = 7; in_b = 7; end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1 || out_result !== 61 || out_cmd !== 1 || out_zero !== 0) begin
        n_bad++; $display("FAIL stall_hold %0d: got v=%b r=%h c=%0d z=%b want 1/3d/1/0",
                          i, out_valid, out_result, out_cmd, out_zero);
      end
      n_cmp++;
      if (in_ready !== 0 || alu_a !== 45 || op_count !== 16'(exp_cnt)) begin
        n_bad++; $display("FAIL stall_ignore %0d: got r=%b a=%0d n=%0d want 0/45/%0d",
                          i, in_ready, alu_a, op_count, exp_cnt);
      end
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1 exp_cnt++;
    n_cmp++;
    if (op_count !== 16'(exp_cnt) || out_valid !== 0) begin
      n_bad++; $display("FAIL stall_release: got n=%0d v=%b want %0d/0",
                        op_count, out_valid, exp_cnt);
    end
    repeat (2) @(posedge clk);
    #1 out_ready = 0;
    n_cmp++;
    if (op_count !== 16'(exp_cnt) || in_ready !== 1 || out_valid !== 0) begin
      n_bad++; $display("FAIL idle_ready: got n=%0d r=%b v=%b want %0d/1/0",
                        op_count, in_ready, out_valid, exp_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    do_op(3'd7, 9, 9, 0, 5'b00001, 1);
    n_cmp++;
    if (err_illegal !== 1 || alu_a !== 45 || alu_b !== 21) begin
      n_bad++; $display("FAIL illegal_state: got e=%b a=%0d b=%0d want 1/45/21",
                        err_illegal, alu_a, alu_b);
    end
    do_op(3'd2, 45, 21, 66, 5'b00010, 2);
    n_cmp++;
    if (err_illegal !== 1) begin
      n_bad++; $display("FAIL illegal_sticky: got %b want 1", err_illegal);
    end
  endtask

  task automatic test_settle3;
    int lat;
    in_valid3 = 1; in_cmd3 = 3'd0; in_a3 = 45; in_b3 = 21;
    @(posedge clk); #1 in_valid3 = 0;
    lat = 1;
    while (out_valid3 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
    n_cmp++;
    if (lat != 4 || out_result3 !== 5) begin
      n_bad++; $display("FAIL s3_latency: got lat=%0d r=%h want 4/5", lat, out_result3);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (op_count3 !== 1) begin
      n_bad++; $display("FAIL s3_count: got %0d want 1", op_count3);
    end
    @(negedge clk);
    in_valid3 = 1; in_cmd3 = 3'd2; in_a3 = 1; in_b3 = 2;
    @(posedge clk); #1 in_valid3 = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready3 !== 0 || out_valid3 !== 0 || alu_op3 !== 5'b00010) begin
      n_bad++; $display("FAIL s3_exec: got r=%b v=%b op=%b want 0/0/00010",
                        in_ready3, out_valid3, alu_op3);
    end
    #1 rst3 = 0;
    #1;
    n_cmp++;
    if ({in_ready3, out_valid3, out_zero3, err3} !== 4'b1010 ||
        {alu_a3, alu_b3, out_result3} !== '0 || alu_op3 !== 0 ||
        out_cmd3 !== 0 || op_count3 !== 0) begin
      n_bad++; $display("FAIL s3_abort: got f=%b a=%h b=%h r=%h op=%b c=%0d n=%0d want reset",
                        {in_ready3, out_valid3, out_zero3, err3}, alu_a3, alu_b3,
                        out_result3, alu_op3, out_cmd3, op_count3);
    end
    @(negedge clk) rst3 = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid3 !== 0 || op_count3 !== 0) begin
        n_bad++; $display("FAIL s3_after %0d: got v=%b n=%0d want 0/0",
                          i, out_valid3, op_count3);
      end
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic;
    test_stall;
    test_illegal;
    test_settle3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
